sha1_padder: RTL and testbench
==============================

// Module: sha1_padder
// PURPOSE
//  Upstream stage of sha1core. Accepts a message as a byte stream with valid/ready handshake.
//  Packs bytes big-endian into 32-bit words and appends the 0x80 byte, zero fill and 64-bit bit length.
//  Presents the resulting 512-bit blocks word-by-word on sha1core's wr/data/busy interface.
//  One message per start of operation. Zero-length messages are not supported (length >= 1 byte).
// PARAMETERS
//  LEN_W  61  width of internal byte counter; bit length = {cnt,3'b0} zero-extended to 64 bits
// PORTS
//  clk        in   1   clock; all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   byte on in_data is valid
//  in_data    in   8   message byte, first byte of message first
//  in_last    in   1   qualifies in_valid: this is the final byte of the message
//  in_ready   out  1   padder accepts in_data this cycle (in_valid && in_ready)
//  core_busy  in   1   sha1core busy; a word transfers only when wr && !core_busy
//  wr         out  1   data holds a valid word for sha1core
//  data       out  32  word to sha1core
//  done       out  1   one-cycle pulse after word 15 of the final block transfers
// BEHAVIOUR
//  Reset (async, rst=1): in_ready=0, wr=0, data=0, done=0, byte count=0, word index=0, state=DATA.
//  First cycle after reset release: in_ready=1.
//  Output transfer: a word moves when wr=1 and core_busy=0. While wr=1 and core_busy=1, hold wr and data stable.
//  in_ready=1 only in state DATA with no output word pending, so at most one word is buffered.
//  Packing: the first byte of each word goes to [31:24], then [23:16], [15:8], [7:0].
//  A word is raised on wr when its 4th byte is accepted, or when in_last is accepted (partial word).
//  Word index wi counts 0..15 per block and advances on each transfer. It wraps 15->0.
//  States:
//   DATA   : accept bytes. On in_last at byte slot k<3, append 0x80 in slot k+1, zero the rest, emit the word.
//            On in_last at slot 3, emit the word, then go to PAD80. Otherwise, after emitting the 0x80 word, go to ZERO.
//   PAD80  : emit 0x80000000, then go to ZERO.
//   ZERO   : emit 0x00000000 until the next transfer lands at wi==14. LEN_HI is entered at wi==14 only.
//            If the 0x80 word used wi 14 or 15, zero-fill to wi 15 first.
//            Then emit a whole extra block of 14 zero words.
//   LEN_HI : emit bitlen[63:32] at wi==14.
//   LEN_LO : emit bitlen[31:0] at wi==15. On its transfer pulse done, then return to DATA.
//            in_ready rises one cycle later; the byte count clears to 0.
//  Byte count increments on each accepted byte, including the last. It is frozen from in_last until done.
//  in_valid without in_ready is ignored; in_last is only sampled with an accepted byte.
//  Reset mid-message: everything returns to reset values immediately. No partial block is completed.
//   The testbench also resets sha1core.
//  Counter overflow beyond 2^LEN_W bytes is unspecified.
// STRUCTURE
//  sha1_pkg: typedef enum state_t {DATA,PAD80,ZERO,LEN_HI,LEN_LO};
//   localparams BLOCK_WORDS=16, LEN_WORD_HI_IDX=14, PAD_WORD=32'h80000000.
//  Sub-module sha1_byte_packer: 8->32 big-endian packer with slot counter and pad-byte insertion.
//   Outputs word + word_valid + last_slot. The FSM, word index and length counter stay in sha1_padder.
// TESTING (bench drives sha1_padder -> sha1core, checks word sequence and digest)
//  "abc", no backpressure -> words 61626380, 14x00000000, 00000018.
//   done once; digest a9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d.
//  55 x 8'h61 -> one block: 13 data words, 61616180, 00000000, 000001B8.
//   done after 16 transfers.
//  56 x 8'h61 -> block1: 14 data words, 80000000, 00000000.
//   Block2: 14 zeros, 00000000, 000001C0. 32 transfers in total.
//  64 x 8'h61 (in_last on slot 3) -> 16 data words.
//   Then 80000000, 13 zeros, 00000000, 00000200.
//  Backpressure: hold core_busy=1 for 20 cycles mid-block -> wr and data stable, in_ready=0, no word lost or duplicated.
//   Sequence identical to the unstalled run.
//  Assert rst for 1 cycle after 7 bytes of a message -> wr=0, in_ready=0 asynchronously.
//   Then send "abc" -> same result as the first scenario.

Source files
------------

// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - shared state encoding and block-layout constants for the SHA-1 padder
package sha1_pkg;

    typedef enum logic [2:0] {
        DATA,
        PAD80,
        ZERO,
        LEN_HI,
        LEN_LO
    } state_t;

    localparam int          BLOCK_WORDS     = 16;
    localparam logic [3:0]  LEN_WORD_HI_IDX = 4'd14;
    localparam logic [31:0] PAD_WORD        = 32'h8000_0000;

endpackage

// File: rtl/sha1_byte_packer.sv
// rtl/sha1_byte_packer.sv - 8->32 big-endian byte packer with 0x80 pad insertion on the last byte
module sha1_byte_packer
    import sha1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    input  logic        last,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last_slot
);

    logic [31:0] acc;
    logic [1:0]  slot;

    assign last_slot  = (slot == 2'd3);
    assign word_valid = accept && (last_slot || last);

    // Bytes below the current slot are always zero in acc, so the pad only needs the 0x80 marker.
    always_comb begin
        word = acc;
        case (slot)
            2'd0:    word = {byte_data, (last ? PAD_WORD[31:8] : 24'h0)};
            2'd1:    word = {acc[31:24], byte_data, (last ? PAD_WORD[31:16] : 16'h0)};
            2'd2:    word = {acc[31:16], byte_data, (last ? PAD_WORD[31:24] : 8'h0)};
            default: word = {acc[31:8], byte_data};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= 32'h0;
            slot <= 2'd0;
        end else if (accept) begin
            if (word_valid) begin
                acc  <= 32'h0;
                slot <= 2'd0;
            end else begin
                acc  <= word;
                slot <= slot + 2'd1;
            end
        end
    end

endmodule

// File: rtl/sha1_padder.sv
// rtl/sha1_padder.sv - byte-stream to padded 512-bit block word stream for sha1core
module sha1_padder
    import sha1_pkg::*;
#(
    parameter int LEN_W = 61
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        core_busy,
    output logic        wr,
    output logic [31:0] data,
    output logic        done
);

    localparam int WI_W = $clog2(BLOCK_WORDS);

    state_t            state;
    logic [LEN_W-1:0]  byte_cnt;
    logic [WI_W-1:0]   wi;
    logic [WI_W-1:0]   load_idx;
    logic              accept;
    logic              xfer;
    logic              can_load;
    logic [31:0]       pk_word;
    logic              pk_valid;
    logic              pk_last_slot;
    logic [63:0]       bitlen;

    assign accept   = in_valid && in_ready;
    assign xfer     = wr && !core_busy;
    assign can_load = !wr || xfer;
    // Block position the next loaded word will occupy once it transfers.
    assign load_idx = xfer ? wi + WI_W'(1) : wi;
    assign bitlen   = 64'({byte_cnt, 3'b000});

    sha1_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .accept     (accept),
        .byte_data  (in_data),
        .last       (in_last),
        .word       (pk_word),
        .word_valid (pk_valid),
        .last_slot  (pk_last_slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DATA;
            in_ready <= 1'b0;
            wr       <= 1'b0;
            data     <= 32'h0;
            done     <= 1'b0;
            byte_cnt <= '0;
            wi       <= '0;
        end else begin
            done <= 1'b0;
            if (xfer) begin
                wi <= wi + WI_W'(1);
            end
            if (accept) begin
                byte_cnt <= byte_cnt + LEN_W'(1);
            end
            case (state)
                DATA: begin
                    if (pk_valid) begin
                        wr       <= 1'b1;
                        data     <= pk_word;
                        in_ready <= 1'b0;
                        if (in_last) begin
                            state <= pk_last_slot ? PAD80 : ZERO;
                        end
                    end else if (xfer) begin
                        wr       <= 1'b0;
                        in_ready <= 1'b1;
                    end else if (!wr) begin
                        in_ready <= 1'b1;
                    end
                end
                PAD80: begin
                    if (can_load) begin
                        wr    <= 1'b1;
                        data  <= PAD_WORD;
                        state <= ZERO;
                    end
                end
                ZERO: begin
                    if (can_load) begin
                        wr <= 1'b1;
                        if (load_idx == LEN_WORD_HI_IDX) begin
                            data  <= bitlen[63:32];
                            state <= LEN_HI;
                        end else begin
                            data <= 32'h0;
                        end
                    end
                end
                LEN_HI: begin
                    if (can_load) begin
                        wr    <= 1'b1;
                        data  <= bitlen[31:0];
                        state <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        wr       <= 1'b0;
                        done     <= 1'b1;
                        byte_cnt <= '0;
                        state    <= DATA;
                    end
                end
                default: state <= DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_padder.sv
// tb/tb_sha1_padder.sv - scoreboard bench for sha1_padder with a padding reference and SHA-1 digest check
module tb_sha1_padder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        core_busy = 1'b0;
    logic        wr;
    logic [31:0] data;
    logic        done;

    sha1_padder #(.LEN_W(61)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .core_busy (core_busy),
        .wr        (wr),
        .data      (data),
        .done      (done)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          xfers = 0;
    int          done_cnt = 0;
    int          stall_at = 0;
    int          stall_left = 0;
    bit          expect_done = 0;
    bit          rand_busy = 0;
    bit          stall_arm = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = 32'h0;
    logic [32:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [7:0]  msg_q[$];

    localparam logic [159:0] ABC_DIGEST = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Standard SHA-1 message padding, worked out on bytes and then cut into words.
    task automatic push_expected();
        logic [7:0]  p[$];
        logic [63:0] bl;
        int          nw;
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg_q.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
        nw = p.size() / 4;
        for (int i = 0; i < nw; i++)
            exp_q.push_back({(i == nw - 1), p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]});
    endtask

    function automatic logic [159:0] digest_of_obs();
        logic [31:0] h[5];
        logic [31:0] w[80];
        logic [31:0] a, b, c, d, e, f, k, t;
        h = '{32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
        for (int blk = 0; blk < obs_q.size() / 16; blk++) begin
            for (int i = 0; i < 16; i++) w[i] = obs_q[blk*16 + i];
            for (int i = 16; i < 80; i++) begin
                t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
                w[i] = {t[30:0], t[31]};
            end
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
            for (int i = 0; i < 80; i++) begin
                if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
                else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
                else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
                else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
                t = {a[26:0], a[31:27]} + f + e + k + w[i];
                e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
            end
            h[0] = h[0] + a; h[1] = h[1] + b; h[2] = h[2] + c; h[3] = h[3] + d; h[4] = h[4] + e;
        end
        return {h[0], h[1], h[2], h[3], h[4]};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_wr", wr, 1'b1);
                check("hold_data", data, prev_data);
            end
            if (wr) check("ready_low_while_wr", in_ready, 1'b0);
            if (expect_done) begin
                check("done_pulse", done, 1'b1);
                expect_done = 0;
            end else if (done) begin
                check("spurious_done", done, 1'b0);
            end
            if (done) done_cnt++;
            if (wr && !core_busy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word: got %08h expected no word", data);
                end else begin
                    logic [32:0] ent;
                    ent = exp_q.pop_front();
                    check("word", data, ent[31:0]);
                    if (ent[32]) expect_done = 1;
                end
                obs_q.push_back(data);
                xfers++;
            end
            prev_stall = wr && core_busy;
            prev_data  = data;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_arm && xfers >= stall_at) begin
                stall_arm  = 0;
                stall_left = 20;
            end
            if (stall_left > 0) begin
                core_busy = 1'b1;
                stall_left--;
            end else begin
                core_busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
        end
    end

    task automatic send_bytes(input int n, input bit gaps);
        int guard;
        bit acc;
        for (int i = 0; i < n; i++) begin
            if (gaps) while ($urandom_range(0, 2) == 0) begin in_valid = 0; @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = msg_q[i];
            in_last  = (i == msg_q.size() - 1);
            guard = 0;
            do begin
                @(negedge clk); acc = in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!acc && guard < 2000);
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: byte %0d not taken, expected acceptance", i);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_msg(input bit gaps);
        int start;
        int guard;
        obs_q.delete();
        xfers = 0;
        push_expected();
        start = done_cnt;
        send_bytes(msg_q.size(), gaps);
        guard = 0;
        while (done_cnt == start && guard < 4000) begin @(posedge clk); #1; guard++; end
        check("message_done", done_cnt - start, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic fill(input int n, input logic [7:0] b);
        msg_q.delete();
        repeat (n) msg_q.push_back(b);
    endtask

    task automatic load_abc();
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_wr", wr, 1'b0);
        check("rst_data", data, 32'h0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", in_ready, 1'b1);

        load_abc();
        run_msg(0);
        check("abc_xfers", xfers, 16);
        check("abc_digest", digest_of_obs(), ABC_DIGEST);

        fill(55, 8'h61); run_msg(0); check("len55_xfers", xfers, 16);
        fill(56, 8'h61); run_msg(0); check("len56_xfers", xfers, 32);
        fill(64, 8'h61); run_msg(0); check("len64_xfers", xfers, 32);

        stall_at  = 5;
        stall_arm = 1;
        fill(56, 8'h61); run_msg(0); check("stall_xfers", xfers, 32);

        rand_busy = 1;
        for (int m = 0; m < 8; m++) begin
            int n;
            n = (m == 0) ? 1 : $urandom_range(1, 140);
            msg_q.delete();
            repeat (n) msg_q.push_back(8'($urandom_range(0, 255)));
            run_msg(1);
        end
        rand_busy = 0;
        repeat (3) @(posedge clk);
        #1;

        fill(10, 8'h5a);
        obs_q.delete();
        xfers = 0;
        push_expected();
        send_bytes(7, 0);
        #1 rst = 1'b1;
        #1;
        check("midrst_wr", wr, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        exp_q.delete();
        expect_done = 0;
        @(posedge clk); #1;
        check("midrst_data", data, 32'h0);
        check("midrst_done", done, 1'b0);
        rst = 1'b0;

        load_abc();
        run_msg(0);
        check("abc2_xfers", xfers, 16);
        check("abc2_digest", digest_of_obs(), ABC_DIGEST);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
